umstr_ethii_rr_mux: RTL and testbench

UMSTR_ETHII_RR_MUX -- requirements
Module: umstr_ethii_rr_mux

---
 rtl/umstr_ethii_pkg.sv | 20 ++
 rtl/umstr_ethii_rr_mux_arb.sv | 47 ++++
 rtl/umstr_ethii_rr_mux.sv | 141 ++++++++++++++
 tb/tb_umstr_ethii_rr_mux.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umstr_ethii_pkg.sv
// Shared types for the Ethernet II round-robin mux: field widths, FSM state
// encoding and the registered header record.
package umstr_ethii_pkg;

    localparam int MAC_W   = 48;
    localparam int ETYPE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_PLD
    } state_t;

    typedef struct packed {
        logic [MAC_W-1:0]   dest;
        logic [MAC_W-1:0]   src;
        logic [ETYPE_W-1:0] etype;
    } eth_hdr_t;

endpackage

// File: rtl/umstr_ethii_rr_mux_arb.sv
// Combinational channel arbiter for umstr_ethii_rr_mux. Round-robin starting
// after 'last'; defining UMSTR_ETHII_MUX_PRIO_EN selects fixed lowest-index priority.
module umstr_rr_arb #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [$clog2(NCH)-1:0] gnt,
    output logic                   gnt_vld
);

    localparam int CW = $clog2(NCH);

`ifdef UMSTR_ETHII_MUX_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Descending scan so the lowest requesting index is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[CW'(i)]) begin
                gnt     = CW'(i);
                gnt_vld = 1'b1;
            end
        end
    end
`else
    logic [CW-1:0] idx;

    // Scan offsets NCH..1 after 'last'; the smallest offset is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = CW'((int'(last) + i) % NCH);
            if (req[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/umstr_ethii_rr_mux.sv
// Multiplexes NCH Ethernet II header+payload sources onto one header port and one
// payload stream. Arbitration mode is chosen by UMSTR_ETHII_MUX_PRIO_EN (see umstr_rr_arb).
module umstr_ethii_rr_mux
    import umstr_ethii_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NCH-1:0][MAC_W-1:0]     ch_mac_dest_i,
    input  logic [NCH-1:0][MAC_W-1:0]     ch_mac_src_i,
    input  logic [NCH-1:0][ETYPE_W-1:0]   ch_mac_type_i,
    input  logic [NCH-1:0]                ch_mac_vld_i,
    output logic [NCH-1:0]                ch_mac_rdy_o,
    input  logic [NCH-1:0][DW-1:0]        ch_tdata_i,
    input  logic [NCH-1:0][DW/8-1:0]      ch_tkeep_i,
    input  logic [NCH-1:0]                ch_tvld_i,
    input  logic [NCH-1:0]                ch_tlast_i,
    output logic [NCH-1:0]                ch_trdy_o,
    output logic [MAC_W-1:0]              hdr_mac_dest_o,
    output logic [MAC_W-1:0]              hdr_mac_src_o,
    output logic [ETYPE_W-1:0]            hdr_mac_type_o,
    output logic                          hdr_mac_vld_o,
    input  logic                          hdr_mac_rdy_i,
    output logic [DW-1:0]                 user_tdata_o,
    output logic [DW/8-1:0]               user_tkeep_o,
    output logic                          user_tlast_o,
    output logic                          user_tvld_o,
    input  logic                          user_trdy_i,
    output logic [$clog2(NCH)-1:0]        hdr_ch_o,
    output logic [$clog2(NCH)-1:0]        user_ch_o
);

    localparam int CW = $clog2(NCH);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] g;
    logic [CW-1:0] last;
    logic [CW-1:0] gnt;
    logic          gnt_vld;
    logic          mac_rdy;
    logic          pld_rdy;
    logic          hdr_acc;
    logic          beat_acc;
    logic          arb_load;
    eth_hdr_t      hdr_in;
    eth_hdr_t      hdr_q;

    umstr_rr_arb #(.NCH(NCH)) u_arb (
        .req     (ch_mac_vld_i),
        .last    (last),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    assign mac_rdy  = ~hdr_mac_vld_o | hdr_mac_rdy_i;
    assign pld_rdy  = ~user_tvld_o | user_trdy_i;
    assign hdr_acc  = (state == SEND_HDR) && ch_mac_vld_i[g] && mac_rdy;
    assign beat_acc = (state == SEND_PLD) && ch_tvld_i[g] && pld_rdy;
    // Re-arbitrating on the closing beat avoids an IDLE bubble between frames.
    assign arb_load = (state == IDLE) || (beat_acc && ch_tlast_i[g]);

    assign hdr_in = '{dest: ch_mac_dest_i[g], src: ch_mac_src_i[g], etype: ch_mac_type_i[g]};
    assign hdr_mac_dest_o = hdr_q.dest;
    assign hdr_mac_src_o  = hdr_q.src;
    assign hdr_mac_type_o = hdr_q.etype;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ch_mac_rdy_o = '0;
        ch_trdy_o    = '0;
        case (state)
            IDLE: begin
                if (gnt_vld) state_nxt = SEND_HDR;
            end
            SEND_HDR: begin
                ch_mac_rdy_o[g] = mac_rdy;
                if (hdr_acc) state_nxt = SEND_PLD;
            end
            SEND_PLD: begin
                ch_trdy_o[g] = pld_rdy;
                if (beat_acc && ch_tlast_i[g]) state_nxt = gnt_vld ? SEND_HDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset pointer to NCH-1 so channel 0 is the first one served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g    <= '0;
            last <= CW'(NCH - 1);
        end else if (arb_load && gnt_vld) begin
            g    <= gnt;
            last <= gnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_mac_vld_o <= 1'b0;
            hdr_q         <= '0;
            hdr_ch_o      <= '0;
        end else if (hdr_acc) begin
            hdr_mac_vld_o <= 1'b1;
            hdr_q         <= hdr_in;
            hdr_ch_o      <= g;
        end else if (mac_rdy) begin
            hdr_mac_vld_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            user_tvld_o  <= 1'b0;
            user_tdata_o <= '0;
            user_tkeep_o <= '0;
            user_tlast_o <= 1'b0;
            user_ch_o    <= '0;
        end else if (beat_acc) begin
            user_tvld_o  <= 1'b1;
            user_tdata_o <= ch_tdata_i[g];
            user_tkeep_o <= ch_tkeep_i[g];
            user_tlast_o <= ch_tlast_i[g];
            user_ch_o    <= g;
        end else if (pld_rdy) begin
            user_tvld_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_umstr_ethii_rr_mux.sv
// Randomized scoreboard bench for umstr_ethii_rr_mux (NCH=4, DW=64): per-channel
// frame queues, expected grant order for directed scenarios, stall and reset cases.
module tb_umstr_ethii_rr_mux;
    import umstr_ethii_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int CW  = $clog2(NCH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic                        clk;
    logic                        reset_n;
    logic [NCH-1:0][MAC_W-1:0]   ch_mac_dest_i;
    logic [NCH-1:0][MAC_W-1:0]   ch_mac_src_i;
    logic [NCH-1:0][ETYPE_W-1:0] ch_mac_type_i;
    logic [NCH-1:0]              ch_mac_vld_i;
    logic [NCH-1:0]              ch_mac_rdy_o;
    logic [NCH-1:0][DW-1:0]      ch_tdata_i;
    logic [NCH-1:0][KW-1:0]      ch_tkeep_i;
    logic [NCH-1:0]              ch_tvld_i;
    logic [NCH-1:0]              ch_tlast_i;
    logic [NCH-1:0]              ch_trdy_o;
    logic [MAC_W-1:0]            hdr_mac_dest_o;
    logic [MAC_W-1:0]            hdr_mac_src_o;
    logic [ETYPE_W-1:0]          hdr_mac_type_o;
    logic                        hdr_mac_vld_o;
    logic                        hdr_mac_rdy_i;
    logic [DW-1:0]               user_tdata_o;
    logic [KW-1:0]               user_tkeep_o;
    logic                        user_tlast_o;
    logic                        user_tvld_o;
    logic                        user_trdy_i;
    logic [CW-1:0]               hdr_ch_o;
    logic [CW-1:0]               user_ch_o;

    umstr_ethii_rr_mux #(.NCH(NCH), .DW(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ch_mac_dest_i  (ch_mac_dest_i),
        .ch_mac_src_i   (ch_mac_src_i),
        .ch_mac_type_i  (ch_mac_type_i),
        .ch_mac_vld_i   (ch_mac_vld_i),
        .ch_mac_rdy_o   (ch_mac_rdy_o),
        .ch_tdata_i     (ch_tdata_i),
        .ch_tkeep_i     (ch_tkeep_i),
        .ch_tvld_i      (ch_tvld_i),
        .ch_tlast_i     (ch_tlast_i),
        .ch_trdy_o      (ch_trdy_o),
        .hdr_mac_dest_o (hdr_mac_dest_o),
        .hdr_mac_src_o  (hdr_mac_src_o),
        .hdr_mac_type_o (hdr_mac_type_o),
        .hdr_mac_vld_o  (hdr_mac_vld_o),
        .hdr_mac_rdy_i  (hdr_mac_rdy_i),
        .user_tdata_o   (user_tdata_o),
        .user_tkeep_o   (user_tkeep_o),
        .user_tlast_o   (user_tlast_o),
        .user_tvld_o    (user_tvld_o),
        .user_trdy_i    (user_trdy_i),
        .hdr_ch_o       (hdr_ch_o),
        .user_ch_o      (user_ch_o)
    );

    eth_hdr_t drv_hdr[NCH][$];
    beat_t    drv_beat[NCH][$];
    eth_hdr_t exp_hdr[NCH][$];
    beat_t    exp_beat[NCH][$];
    int       exp_order[$];

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int frame_cnt = 0;
    int cyc = 0;
    int last_tlast_cyc = 0;
    bit seen_tlast = 1'b0;
    bit gap_chk = 1'b0;
    bit flush = 1'b0;
    bit gaps = 1'b0;
    bit stall = 1'b0;
    bit hold = 1'b0;
    logic [NCH-1:0] hfire;
    logic [NCH-1:0] bfire;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int c, input int nbeats, input bit fixed,
                                 input logic [DW-1:0] fdata, input logic [KW-1:0] fkeep);
        eth_hdr_t    h;
        beat_t       b;
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        h.dest = r[47:0];
        r = {$urandom(), $urandom()};
        h.src = r[47:0];
        h.etype = 16'($urandom());
        drv_hdr[c].push_back(h);
        exp_hdr[c].push_back(h);
        for (int i = 0; i < nbeats; i++) begin
            b.data = fixed ? fdata : {$urandom(), $urandom()};
            b.keep = fixed ? fkeep : KW'($urandom());
            b.last = (i == nbeats - 1);
            drv_beat[c].push_back(b);
            exp_beat[c].push_back(b);
        end
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("frames_done", 128'(frame_cnt >= target), 128'(1));
    endtask

    // Source drivers and sinks: inputs change on the falling edge, handshakes are
    // evaluated once the combinational ready outputs have settled.
    initial begin
        ch_mac_dest_i = '0;
        ch_mac_src_i  = '0;
        ch_mac_type_i = '0;
        ch_mac_vld_i  = '0;
        ch_tdata_i    = '0;
        ch_tkeep_i    = '0;
        ch_tvld_i     = '0;
        ch_tlast_i    = '0;
        hdr_mac_rdy_i = 1'b0;
        user_trdy_i   = 1'b0;
        hfire         = '0;
        bfire         = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (flush) begin
                    drv_hdr[c].delete();
                    drv_beat[c].delete();
                    ch_mac_vld_i[c] = 1'b0;
                    ch_tvld_i[c]    = 1'b0;
                end else begin
                    if (hfire[c]) begin
                        drv_hdr[c].delete(0);
                        ch_mac_vld_i[c] = 1'b0;
                    end
                    if (!ch_mac_vld_i[c] && drv_hdr[c].size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
                        ch_mac_vld_i[c]  = 1'b1;
                        ch_mac_dest_i[c] = drv_hdr[c][0].dest;
                        ch_mac_src_i[c]  = drv_hdr[c][0].src;
                        ch_mac_type_i[c] = drv_hdr[c][0].etype;
                    end
                    if (bfire[c]) begin
                        drv_beat[c].delete(0);
                        ch_tvld_i[c] = 1'b0;
                    end
                    if (!ch_tvld_i[c] && drv_beat[c].size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
                        ch_tvld_i[c]  = 1'b1;
                        ch_tdata_i[c] = drv_beat[c][0].data;
                        ch_tkeep_i[c] = drv_beat[c][0].keep;
                        ch_tlast_i[c] = drv_beat[c][0].last;
                    end
                end
            end
            hdr_mac_rdy_i = stall ? 1'($urandom_range(1)) : 1'b1;
            user_trdy_i   = hold ? 1'b0 : (stall ? 1'($urandom_range(1)) : 1'b1);
            #1;
            hfire = ch_mac_vld_i & ch_mac_rdy_o;
            bfire = ch_tvld_i & ch_trdy_o;
        end
    end

    // Monitor: every completed output transfer is popped against the per-channel queues.
    initial begin
        int c;
        eth_hdr_t ah;
        beat_t    ab;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (reset_n && hdr_mac_vld_o && hdr_mac_rdy_i) begin
                c = int'(hdr_ch_o);
                if (exp_order.size() != 0) begin
                    checkOutput("hdr_order", 128'(hdr_ch_o), 128'(exp_order[0]));
                    exp_order.delete(0);
                end
                if (gap_chk && seen_tlast)
                    checkOutput("no_idle_gap", 128'(cyc - last_tlast_cyc), 128'(1));
                checkOutput("hdr_expected", 128'(exp_hdr[c].size() != 0), 128'(1));
                if (exp_hdr[c].size() != 0) begin
                    ah = '{dest: hdr_mac_dest_o, src: hdr_mac_src_o, etype: hdr_mac_type_o};
                    checkOutput("hdr_fields", 128'(ah), 128'(exp_hdr[c][0]));
                    exp_hdr[c].delete(0);
                end
            end
            if (reset_n && user_tvld_o && user_trdy_i) begin
                c = int'(user_ch_o);
                beat_cnt++;
                if (user_tlast_o) begin
                    frame_cnt++;
                    last_tlast_cyc = cyc;
                    seen_tlast = 1'b1;
                end
                checkOutput("beat_expected", 128'(exp_beat[c].size() != 0), 128'(1));
                if (exp_beat[c].size() != 0) begin
                    ab = '{data: user_tdata_o, keep: user_tkeep_o, last: user_tlast_o};
                    checkOutput("beat_fields", 128'(ab), 128'(exp_beat[c][0]));
                    exp_beat[c].delete(0);
                end
            end
        end
    end

    initial begin
        int start;
        int n;
        logic [DW-1:0] snap_data;
        logic [KW-1:0] snap_keep;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("rst_hdr_vld",  128'(hdr_mac_vld_o), 128'(0));
        checkOutput("rst_user_vld", 128'(user_tvld_o), 128'(0));
        checkOutput("rst_mac_rdy",  128'(ch_mac_rdy_o), 128'(0));
        checkOutput("rst_trdy",     128'(ch_trdy_o), 128'(0));
        checkOutput("rst_tdata",    128'(user_tdata_o), 128'(0));
        checkOutput("rst_hdr_dest", 128'(hdr_mac_dest_o), 128'(0));
        checkOutput("rst_chans",    128'({hdr_ch_o, user_ch_o}), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] all four channels request 3-beat frames together");
        gap_chk = 1'b1;
        seen_tlast = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            applyStimulus(c, 3, 1'b0, '0, '0);
            exp_order.push_back(c);
        end
        waitFrames(frame_cnt + 4, 200);
        gap_chk = 1'b0;
        checkOutput("order_drained_a", 128'(exp_order.size()), 128'(0));

        $display("[TB] channel 1 re-requests alongside channel 3");
        applyStimulus(1, 2, 1'b0, '0, '0);
        applyStimulus(1, 2, 1'b0, '0, '0);
        applyStimulus(3, 2, 1'b0, '0, '0);
`ifdef UMSTR_ETHII_MUX_PRIO_EN
        exp_order.push_back(1);
        exp_order.push_back(1);
        exp_order.push_back(3);
`else
        exp_order.push_back(1);
        exp_order.push_back(3);
        exp_order.push_back(1);
`endif
        waitFrames(frame_cnt + 3, 200);
        checkOutput("order_drained_b", 128'(exp_order.size()), 128'(0));

        $display("[TB] payload sink stalls for five cycles mid-frame");
        start = beat_cnt;
        applyStimulus(2, 6, 1'b0, '0, '0);
        exp_order.push_back(2);
        n = 0;
        while (beat_cnt < start + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("stall_reached", 128'(beat_cnt >= start + 2), 128'(1));
        hold = 1'b1;
        @(negedge clk);
        #3;
        snap_data = user_tdata_o;
        snap_keep = user_tkeep_o;
        checkOutput("stall_vld", 128'(user_tvld_o), 128'(1));
        checkOutput("stall_trdy", 128'(ch_trdy_o), 128'(0));
        repeat (4) begin
            @(negedge clk);
            #3;
            checkOutput("stall_tdata", 128'(user_tdata_o), 128'(snap_data));
            checkOutput("stall_tkeep", 128'(user_tkeep_o), 128'(snap_keep));
            checkOutput("stall_trdy", 128'(ch_trdy_o), 128'(0));
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        waitFrames(frame_cnt + 1, 200);

        $display("[TB] single-beat frame on channel 0");
        applyStimulus(0, 1, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
        exp_order.push_back(0);
        waitFrames(frame_cnt + 1, 100);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("idle_mac_rdy", 128'(ch_mac_rdy_o), 128'(0));
        checkOutput("idle_trdy", 128'(ch_trdy_o), 128'(0));
        checkOutput("idle_outputs", 128'({hdr_mac_vld_o, user_tvld_o}), 128'(0));

        $display("[TB] reset during beat 2 of a 4-beat frame");
        start = beat_cnt;
        applyStimulus(2, 4, 1'b0, '0, '0);
        exp_order.push_back(2);
        n = 0;
        while (beat_cnt < start + 1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("midreset_reached", 128'(beat_cnt >= start + 1), 128'(1));
        flush = 1'b1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_vld", 128'({hdr_mac_vld_o, user_tvld_o}), 128'(0));
        checkOutput("midrst_rdy", 128'({ch_mac_rdy_o, ch_trdy_o}), 128'(0));
        checkOutput("midrst_tdata", 128'(user_tdata_o), 128'(0));
        exp_order.delete();
        for (int c = 0; c < NCH; c++) begin
            exp_hdr[c].delete();
            exp_beat[c].delete();
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        flush = 1'b0;
        applyStimulus(3, 2, 1'b0, '0, '0);
        applyStimulus(0, 2, 1'b0, '0, '0);
        exp_order.push_back(0);
        exp_order.push_back(3);
        @(negedge clk);
        reset_n = 1'b1;
        waitFrames(frame_cnt + 2, 100);
        checkOutput("order_drained_c", 128'(exp_order.size()), 128'(0));

        $display("[TB] random traffic with stalls, 1000 frames");
        gaps = 1'b1;
        stall = 1'b1;
        start = frame_cnt;
        for (int i = 0; i < 1000; i++)
            applyStimulus(int'($urandom_range(NCH - 1)), int'($urandom_range(6, 1)), 1'b0, '0, '0);
        waitFrames(start + 1000, 60000);
        gaps = 1'b0;
        stall = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            checkOutput("hdr_left", 128'(exp_hdr[c].size()), 128'(0));
            checkOutput("beat_left", 128'(exp_beat[c].size()), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
